// File: rtl/rotate_pkg.sv
// Shared definitions for the rotation detector: default widths and FSM states.
package rotate_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rotate_detect.sv
// Finds the smallest left rotation of ref_data that equals rot_data by stepping
// a 1-bit rotator once per cycle, then reports it as the shortest left/right shift.
module rotate_detect
    import rotate_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ref_data,
    input  logic [WIDTH-1:0] rot_data,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [SHW-1:0]   shift_amt,
    output logic             dir
);

    localparam logic [SHW-1:0] K_LAST  = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] K_HALF  = SHW'(WIDTH / 2);
    localparam logic [SHW:0]   WIDTH_W = (SHW + 1)'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] tgt;
    logic [SHW-1:0]   k;
    logic             match;
    logic             last;
    logic [SHW:0]     wrap_amt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        match      = (cur == tgt);
        last       = (k == K_LAST);
        wrap_amt   = WIDTH_W - {1'b0, k};
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                busy = 1'b1;
                if (match || last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Rotations beyond half a word are reported as the shorter right shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            tgt       <= '0;
            k         <= '0;
            found     <= 1'b0;
            dir       <= 1'b0;
            shift_amt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur <= ref_data;
                        tgt <= rot_data;
                        k   <= '0;
                    end
                end
                SEARCH: begin
                    if (match) begin
                        found <= 1'b1;
                        if (k <= K_HALF) begin
                            dir       <= 1'b1;
                            shift_amt <= k;
                        end else begin
                            dir       <= 1'b0;
                            shift_amt <= wrap_amt[SHW-1:0];
                        end
                    end else if (last) begin
                        found     <= 1'b0;
                        dir       <= 1'b0;
                        shift_amt <= '0;
                    end else begin
                        cur <= {cur[WIDTH-2:0], cur[WIDTH-1]};
                        k   <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_detect.sv
// Directed-vector bench for rotate_detect with hand-computed expectations.
module tb_rotate_detect;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ref_data;
    logic [31:0] rot_data;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  shift_amt;
    logic        dir;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        string       name;
        logic [31:0] ref_w;
        logic [31:0] rot_w;
        int          cyc;
        logic        f;
        logic        d;
        logic [4:0]  s;
    } vec_t;

    rotate_detect #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ref_data  (ref_data),
        .rot_data  (rot_data),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .shift_amt (shift_amt),
        .dir       (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then count edges until done is seen (bounded).
    task automatic start_and_wait(input logic [31:0] r, input logic [31:0] t, output int cycles);
        @(posedge clk); #1;
        ref_data = r;
        rot_data = t;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ref_data = '0; rot_data = '0;
        #12;
        check_count++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_count++;
        check_count++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else pass_count++;
        check_count++; if (found !== 1'b0) $display("[TB] FAIL reset_found: got %b expected 0", found); else pass_count++;
        check_count++; if (dir !== 1'b0) $display("[TB] FAIL reset_dir: got %b expected 0", dir); else pass_count++;
        check_count++; if (shift_amt !== 5'd0) $display("[TB] FAIL reset_shift_amt: got %0d expected 0", shift_amt); else pass_count++;
        #3; rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t vecs[$];
        int   cycles;
        vecs.push_back('{"left3",    32'h0000_0001, 32'h0000_0008,  4, 1'b1, 1'b1, 5'd3});
        vecs.push_back('{"nomatch",  32'h0000_0001, 32'h0000_0003, 32, 1'b0, 1'b0, 5'd0});
        vecs.push_back('{"right1",   32'h0000_0001, 32'h8000_0000, 32, 1'b1, 1'b0, 5'd1});
        vecs.push_back('{"identity", 32'hA5A5_A5A5, 32'hA5A5_A5A5,  1, 1'b1, 1'b1, 5'd0});
        vecs.push_back('{"periodic", 32'hAAAA_AAAA, 32'h5555_5555,  2, 1'b1, 1'b1, 5'd1});
        vecs.push_back('{"half16",   32'h0000_0001, 32'h0001_0000, 17, 1'b1, 1'b1, 5'd16});
        vecs.push_back('{"k17",      32'h0000_0001, 32'h0002_0000, 18, 1'b1, 1'b0, 5'd15});
        vecs.push_back('{"nomatch2", 32'h0000_0001, 32'h0000_0003, 32, 1'b0, 1'b0, 5'd0});
        foreach (vecs[i]) begin
            start_and_wait(vecs[i].ref_w, vecs[i].rot_w, cycles);
            check_count++; if (cycles != vecs[i].cyc) $display("[TB] FAIL %s_latency: got %0d expected %0d", vecs[i].name, cycles, vecs[i].cyc); else pass_count++;
            check_count++; if (found !== vecs[i].f) $display("[TB] FAIL %s_found: got %b expected %b", vecs[i].name, found, vecs[i].f); else pass_count++;
            check_count++; if (dir !== vecs[i].d) $display("[TB] FAIL %s_dir: got %b expected %b", vecs[i].name, dir, vecs[i].d); else pass_count++;
            check_count++; if (shift_amt !== vecs[i].s) $display("[TB] FAIL %s_shift_amt: got %0d expected %0d", vecs[i].name, shift_amt, vecs[i].s); else pass_count++;
        end
    endtask

    task automatic test_done_pulse();
        int cycles;
        start_and_wait(32'h0000_0001, 32'h0000_0008, cycles);
        check_count++; if (busy !== 1'b0) $display("[TB] FAIL pulse_busy_in_done: got %b expected 0", busy); else pass_count++;
        @(posedge clk); #1;
        check_count++; if (done !== 1'b0) $display("[TB] FAIL pulse_done_width: got %b expected 0", done); else pass_count++;
        ref_data = 32'h0000_0001; rot_data = 32'h0000_0003;
        repeat (3) @(posedge clk); #1;
        check_count++; if (shift_amt !== 5'd3) $display("[TB] FAIL pulse_hold_shift: got %0d expected 3", shift_amt); else pass_count++;
        check_count++; if (found !== 1'b1) $display("[TB] FAIL pulse_hold_found: got %b expected 1", found); else pass_count++;
    endtask

    task automatic test_abort();
        logic saw_done = 1'b0;
        int   cycles;
        @(posedge clk); #1;
        ref_data = 32'h0000_0001; rot_data = 32'h8000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (c == 4) begin
                start = 1'b1; ref_data = 32'h0000_0001; rot_data = 32'h0000_0002;
            end
            if (c == 5) start = 1'b0;
        end
        check_count++; if (saw_done !== 1'b0) $display("[TB] FAIL abort_restart_ignored: got done=%b expected 0", saw_done); else pass_count++;
        check_count++; if (busy !== 1'b1) $display("[TB] FAIL abort_busy_searching: got %b expected 1", busy); else pass_count++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_count++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else pass_count++;
        check_count++; if ({done, found, dir, shift_amt} !== 8'h00) $display("[TB] FAIL abort_outputs: got %h expected 00", {done, found, dir, shift_amt}); else pass_count++;
        #2; rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check_count++; if (saw_done !== 1'b0) $display("[TB] FAIL abort_no_done: got %b expected 0", saw_done); else pass_count++;
        start_and_wait(32'h0000_0001, 32'h0000_0004, cycles);
        check_count++; if (cycles != 3) $display("[TB] FAIL after_abort_latency: got %0d expected 3", cycles); else pass_count++;
        check_count++; if ({found, dir, shift_amt} !== {1'b1, 1'b1, 5'd2}) $display("[TB] FAIL after_abort_result: got %b expected 1100010", {found, dir, shift_amt}); else pass_count++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_done_pulse();
        test_abort();
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
